vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing types and helpers for the dual-mode VGA timing generator.
// Mode 0 / mode 1 selection constants and per-axis limit derivation live here.
package vga_timing_pkg;

   typedef struct packed {
      logic [15:0] view;
      logic [15:0] front;
      logic [15:0] sync;
      logic [15:0] back;
      logic        pol;
   } axis_timing_t;

   typedef struct packed {
      logic [15:0] max;
      logic [15:0] sync_start;
      logic [15:0] sync_end;
   } axis_limits_t;

   localparam logic MODE_0 = 1'b0;
   localparam logic MODE_1 = 1'b1;

   function automatic axis_timing_t make_timing(input int view, input int front,
                                                input int sync, input int back,
                                                input int pol);
      axis_timing_t t;
      t.view  = 16'(view);
      t.front = 16'(front);
      t.sync  = 16'(sync);
      t.back  = 16'(back);
      t.pol   = (pol != 0);
      return t;
   endfunction

   // sync window is [sync_start, sync_end); max is the last position of the axis
   function automatic axis_limits_t axis_limits(input axis_timing_t t);
      axis_limits_t l;
      l.sync_start = t.view + t.front;
      l.sync_end   = l.sync_start + t.sync;
      l.max        = l.sync_end + t.back - 16'd1;
      return l;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA timing generator: position
// counter with wrap, registered sync and blank flags aligned to the position.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         adv,
   input  logic [W-1:0] cur_max,
   input  logic [W-1:0] view,
   input  logic [W-1:0] sync_start,
   input  logic [W-1:0] sync_end,
   input  logic         pol,
   output logic [W-1:0] pos,
   output logic         at_max,
   output logic [W-1:0] pos_nxt,
   output logic         in_view_nxt,
   output logic         sync,
   output logic         blank
);

   logic sync_act_s;

   assign at_max = (pos == cur_max);

   // Next position; the limits (view/sync/pol) already belong to the mode in effect at pos_nxt
   always_comb begin
      if (reset) begin
         pos_nxt = '0;
      end else if (adv && at_max) begin
         pos_nxt = '0;
      end else if (adv) begin
         pos_nxt = pos + W'(1);
      end else begin
         pos_nxt = pos;
      end
      in_view_nxt = (pos_nxt < view);
      sync_act_s  = (pos_nxt >= sync_start) && (pos_nxt < sync_end);
   end

   // Position and flags registered together so they never skew
   always_ff @(posedge clk) begin
      if (reset) begin
         pos   <= '0;
         sync  <= ~pol;
         blank <= 1'b0;
      end else begin
         pos   <= pos_nxt;
         sync  <= sync_act_s ^ ~pol;
         blank <= ~in_view_nxt;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Dual-mode VGA timing generator; mode_req is adopted only at the frame boundary.
// Optional `VGA_TIMING_BORDER_EN adds a registered debug border flag.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int HW         = 11,
   parameter int VW         = 10,
   parameter int M0_H_VIEW  = 426,
   parameter int M0_H_FRONT = 38,
   parameter int M0_H_SYNC  = 13,
   parameter int M0_H_BACK  = 73,
   parameter int M0_V_VIEW  = 720,
   parameter int M0_V_FRONT = 5,
   parameter int M0_V_SYNC  = 5,
   parameter int M0_V_BACK  = 20,
   parameter int M0_HPOL    = 1,
   parameter int M0_VPOL    = 1,
   parameter int M1_H_VIEW  = 640,
   parameter int M1_H_FRONT = 16,
   parameter int M1_H_SYNC  = 96,
   parameter int M1_H_BACK  = 48,
   parameter int M1_V_VIEW  = 480,
   parameter int M1_V_FRONT = 10,
   parameter int M1_V_SYNC  = 2,
   parameter int M1_V_BACK  = 33,
   parameter int M1_HPOL    = 0,
   parameter int M1_VPOL    = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mode_req,
   output logic          mode,
   output logic          hsync,
   output logic          vsync,
   output logic [HW-1:0] hpos,
   output logic [VW-1:0] vpos,
   output logic          hmax,
   output logic          vmax,
   output logic          visible,
   output logic          hblank,
   output logic          vblank,
   output logic          frame_start
`ifdef VGA_TIMING_BORDER_EN
   ,
   output logic          border
`endif
);

   localparam axis_timing_t M0_H = make_timing(M0_H_VIEW, M0_H_FRONT, M0_H_SYNC, M0_H_BACK, M0_HPOL);
   localparam axis_timing_t M0_V = make_timing(M0_V_VIEW, M0_V_FRONT, M0_V_SYNC, M0_V_BACK, M0_VPOL);
   localparam axis_timing_t M1_H = make_timing(M1_H_VIEW, M1_H_FRONT, M1_H_SYNC, M1_H_BACK, M1_HPOL);
   localparam axis_timing_t M1_V = make_timing(M1_V_VIEW, M1_V_FRONT, M1_V_SYNC, M1_V_BACK, M1_VPOL);
   localparam axis_limits_t M0_HL = axis_limits(M0_H);
   localparam axis_limits_t M0_VL = axis_limits(M0_V);
   localparam axis_limits_t M1_HL = axis_limits(M1_H);
   localparam axis_limits_t M1_VL = axis_limits(M1_V);

   if ((int'(M0_HL.max) >= (1 << HW)) || (int'(M1_HL.max) >= (1 << HW)) ||
       (int'(M0_VL.max) >= (1 << VW)) || (int'(M1_VL.max) >= (1 << VW))) begin : g_bad_timing
      $error("vga_timing_gen: mode timing does not fit HW/VW counter width");
   end

   logic          mode_nxt_s;
   logic [HW-1:0] h_cur_max_s, h_view_s, h_ss_s, h_se_s, hpos_nxt_s;
   logic [VW-1:0] v_cur_max_s, v_view_s, v_ss_s, v_se_s, vpos_nxt_s;
   logic          h_pol_s, v_pol_s, h_in_view_s, v_in_view_s;

   // Mode adopted at the wrap from (H_MAX,V_MAX) to (0,0); reset forces mode 0
   always_comb begin
      if (reset) begin
         mode_nxt_s = MODE_0;
      end else if (hmax && vmax) begin
         mode_nxt_s = mode_req;
      end else begin
         mode_nxt_s = mode;
      end
   end

   // Wrap limits follow the current mode, window limits follow the next mode
   always_comb begin
      case (mode)
         MODE_1: begin
            h_cur_max_s = HW'(M1_HL.max);
            v_cur_max_s = VW'(M1_VL.max);
         end
         default: begin
            h_cur_max_s = HW'(M0_HL.max);
            v_cur_max_s = VW'(M0_VL.max);
         end
      endcase
      case (mode_nxt_s)
         MODE_1: begin
            h_view_s = HW'(M1_H.view);
            h_ss_s   = HW'(M1_HL.sync_start);
            h_se_s   = HW'(M1_HL.sync_end);
            h_pol_s  = M1_H.pol;
            v_view_s = VW'(M1_V.view);
            v_ss_s   = VW'(M1_VL.sync_start);
            v_se_s   = VW'(M1_VL.sync_end);
            v_pol_s  = M1_V.pol;
         end
         default: begin
            h_view_s = HW'(M0_H.view);
            h_ss_s   = HW'(M0_HL.sync_start);
            h_se_s   = HW'(M0_HL.sync_end);
            h_pol_s  = M0_H.pol;
            v_view_s = VW'(M0_V.view);
            v_ss_s   = VW'(M0_VL.sync_start);
            v_se_s   = VW'(M0_VL.sync_end);
            v_pol_s  = M0_V.pol;
         end
      endcase
   end

   vga_axis_counter #(.W(HW)) u_h (
      .clk         (clk),
      .reset       (reset),
      .adv         (1'b1),
      .cur_max     (h_cur_max_s),
      .view        (h_view_s),
      .sync_start  (h_ss_s),
      .sync_end    (h_se_s),
      .pol         (h_pol_s),
      .pos         (hpos),
      .at_max      (hmax),
      .pos_nxt     (hpos_nxt_s),
      .in_view_nxt (h_in_view_s),
      .sync        (hsync),
      .blank       (hblank)
   );

   vga_axis_counter #(.W(VW)) u_v (
      .clk         (clk),
      .reset       (reset),
      .adv         (hmax),
      .cur_max     (v_cur_max_s),
      .view        (v_view_s),
      .sync_start  (v_ss_s),
      .sync_end    (v_se_s),
      .pol         (v_pol_s),
      .pos         (vpos),
      .at_max      (vmax),
      .pos_nxt     (vpos_nxt_s),
      .in_view_nxt (v_in_view_s),
      .sync        (vsync),
      .blank       (vblank)
   );

   // Mode, visible and frame strobe registered from next-state values
   always_ff @(posedge clk) begin
      if (reset) begin
         mode        <= MODE_0;
         visible     <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         mode        <= mode_nxt_s;
         visible     <= h_in_view_s && v_in_view_s;
         frame_start <= (hpos_nxt_s == '0) && (vpos_nxt_s == '0);
      end
   end

`ifdef VGA_TIMING_BORDER_EN
   logic [HW-1:0] h_border_end_s;
   logic [VW-1:0] v_border_end_s;

   assign h_border_end_s = h_view_s + HW'(8);
   assign v_border_end_s = v_view_s + VW'(8);

   // Debug frame: first 8 pixels/lines of the front porches just past the view
   always_ff @(posedge clk) begin
      if (reset) begin
         border <= 1'b0;
      end else begin
         border <= !(h_in_view_s && v_in_view_s) &&
                   (hpos_nxt_s < h_border_end_s) && (vpos_nxt_s < v_border_end_s);
      end
   end
`endif

endmodule
